truth_table_checker: RTL and testbench
======================================

# truth_table_checker

Sequential counterpart to the lab's exhaustive stimulus benches. It drives every input combination of a combinational circuit under test, waits a fixed settle time, and samples the circuit's single output. It assembles the captured truth table and compares it against an expected table. It sits beside the combinational DUT on the lab board/top level, so the DUT's function is checked in hardware rather than by eye on a waveform.

## Interface
Parameters:
- N_IN, 3, number of DUT inputs; table width TW = 2**N_IN
- DWELL, 4, settle cycles per vector before sampling (minimum 1)
- EXPECTED, 8'hE8, expected truth table, TW bits; bit k = expected Q for input vector k (stim[N_IN-1] is MSB, i.e. A for N_IN=3)

Ports:
- clk  input  1  sole clock, rising edge
- rst  input  1  reset, asynchronous, active-high
- start  input  1  begin a run; sampled only when not busy
- q  input  1  DUT output
- stim  output  N_IN  DUT input vector, {A,B,C} for N_IN=3
- busy  output  1  run in progress
- done  output  1  run complete; sticky until next accepted start
- pass  output  1  captured table == EXPECTED; valid when done
- table_out  output  TW  captured truth table
- fail_idx  output  N_IN  lowest vector index whose sample differed from EXPECTED; 0 when pass

## Operation
- All outputs reset to 0; state IDLE.
- States: IDLE, APPLY, SAMPLE.
- IDLE: stim=0, busy=0. start=1 -> APPLY, idx=0, dwell count=0, table_out=0, done=0, pass=0, fail_idx=0, fail_seen=0.
- APPLY: stim=idx, busy=1; the dwell counter increments each cycle. When count==DWELL-1 -> SAMPLE.
- SAMPLE: stim still = idx. table_out[idx] <= q.
  - If q != EXPECTED[idx] and !fail_seen: fail_idx <= idx, fail_seen <= 1.
  - If idx == TW-1 -> IDLE, done <= 1, pass <= (final table including this bit == EXPECTED).
  - Otherwise idx <= idx+1, count <= 0, -> APPLY.
- start while busy is ignored (no restart, no queueing). start held high in IDLE after done immediately begins a new run.
- idx does not wrap within a run; the run terminates at TW-1.
- q is treated as synchronous to clk; no internal synchronizer.

## Timing
- Let E0 be the edge at which start is accepted. busy=1 and stim=0 after E0.
- Each vector is held for DWELL+1 cycles: DWELL APPLY cycles plus 1 SAMPLE cycle.
- Vector k is sampled at edge E0+(k+1)*(DWELL+1). stim changes to k+1 at that same edge.
- done=1, pass valid, and busy=0 after edge E0+TW*(DWELL+1). This is 40 cycles for the defaults.
- done, pass, table_out, and fail_idx hold until the next accepted start. They clear at that start edge.
- rst asserted at any time, including mid-run, forces all outputs to 0 and the state to IDLE immediately, without waiting for clk. Partial results are discarded.

## Structure
- Shared package tt_pkg holds:
  - state enum: IDLE, APPLY, SAMPLE
  - a function computing the dwell counter width: $clog2(DWELL) with a minimum of 1
- One natural sub-module, dwell_timer: a counter with clear and enable and a terminal-count output at DWELL-1, instantiated once.
- Vector index, table register, and fail tracking live in the top module.

## Test plan
- Reset: assert rst with start=1 -> stim, busy, done, pass, table_out, fail_idx all 0. No run begins until rst is released.
- Majority DUT (Q=AB+BC+AC), defaults: start pulse -> stim steps 0..7, each held 5 cycles. done rises 40 cycles after start; table_out=8'hE8, pass=1, fail_idx=0.
- q tied 0, EXPECTED=8'hE8 -> table_out=8'h00, pass=0, fail_idx=3.
- Majority DUT, start re-pulsed at cycles 10 and 25 -> run unaffected, done at cycle 40. A start after done clears done at that edge, and a new run completes 40 cycles later.
- rst asserted at cycle 17 mid-run -> all outputs 0 asynchronously. A later start yields a full 40-cycle run with table_out=8'hE8.
- DWELL=1, N_IN=2, XOR DUT, EXPECTED=4'h6 -> each vector held 2 cycles, done 8 cycles after start, pass=1.

Source files
------------

// File: rtl/tt_pkg.sv
// Shared types and helpers for the truth table checker.
// Holds the sequencer state encoding and the dwell counter sizing rule.
package tt_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      APPLY  = 2'd1,
      SAMPLE = 2'd2
   } state_e;

   // A one-cycle dwell still needs a one-bit counter.
   function automatic int dwell_cnt_w(input int dwell);
      return (dwell > 1) ? $clog2(dwell) : 1;
   endfunction

endpackage

// File: rtl/truth_table_checker_if.sv
// Control and result bundle between the checker and its driver.
// The master side starts runs and feeds q; the slave side is the checker.
interface truth_table_checker_if #(
   parameter int N_IN = 3
);
   localparam int TW = 2**N_IN;

   logic            start;
   logic            q;
   logic [N_IN-1:0] stim;
   logic            busy;
   logic            done;
   logic            pass;
   logic [TW-1:0]   table_out;
   logic [N_IN-1:0] fail_idx;

   modport master (
      output start, q,
      input  stim, busy, done, pass, table_out, fail_idx
   );

   modport slave (
      input  start, q,
      output stim, busy, done, pass, table_out, fail_idx
   );

endinterface

// File: rtl/dwell_timer.sv
// Settle-time counter: clear, enable and terminal count at DWELL-1.
module dwell_timer #(
   parameter int DWELL = 4,
   parameter int W     = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic i_clr,
   input  logic i_en,
   output logic o_tc
);

   logic [W-1:0] r_cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt <= '0;
      end else if (i_clr) begin
         r_cnt <= '0;
      end else if (i_en) begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   assign o_tc = (r_cnt == W'(DWELL - 1));

endmodule

// File: rtl/truth_table_checker.sv
// Walks every input vector of a combinational DUT, samples q after a
// settle time and compares the captured truth table with EXPECTED.
module truth_table_checker
   import tt_pkg::*;
#(
   parameter int                 N_IN     = 3,
   parameter int                 DWELL    = 4,
   parameter logic [2**N_IN-1:0] EXPECTED = 8'hE8
) (
   input logic                  clk,
   input logic                  rst,
   truth_table_checker_if.slave bus
);

   localparam int TW = 2**N_IN;
   localparam int CW = dwell_cnt_w(DWELL);

   state_e          r_state;
   logic [N_IN-1:0] r_idx;
   logic [TW-1:0]   r_table;
   logic            r_done;
   logic            r_pass;
   logic            r_fail_seen;
   logic [N_IN-1:0] r_fail_idx;

   logic [TW-1:0]   w_table_nxt;
   logic            w_tc;
   logic            w_last;
   logic            w_mis;

   dwell_timer #(
      .DWELL (DWELL),
      .W     (CW)
   ) u_dwell (
      .clk   (clk),
      .rst   (rst),
      .i_clr (r_state != APPLY),
      .i_en  (r_state == APPLY),
      .o_tc  (w_tc)
   );

   // Table as it will look once the current sample lands.
   always_comb begin
      w_table_nxt        = r_table;
      w_table_nxt[r_idx] = bus.q;
   end

   assign w_last = &r_idx;
   assign w_mis  = (bus.q != EXPECTED[r_idx]);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= IDLE;
         r_idx       <= '0;
         r_table     <= '0;
         r_done      <= 1'b0;
         r_pass      <= 1'b0;
         r_fail_seen <= 1'b0;
         r_fail_idx  <= '0;
      end else begin
         unique case (r_state)
            IDLE: begin
               if (bus.start) begin
                  r_state     <= APPLY;
                  r_idx       <= '0;
                  r_table     <= '0;
                  r_done      <= 1'b0;
                  r_pass      <= 1'b0;
                  r_fail_seen <= 1'b0;
                  r_fail_idx  <= '0;
               end
            end
            APPLY: begin
               if (w_tc) begin
                  r_state <= SAMPLE;
               end
            end
            SAMPLE: begin
               r_table <= w_table_nxt;
               if (w_mis && !r_fail_seen) begin
                  r_fail_idx  <= r_idx;
                  r_fail_seen <= 1'b1;
               end
               if (w_last) begin
                  r_state <= IDLE;
                  r_idx   <= '0;
                  r_done  <= 1'b1;
                  r_pass  <= (w_table_nxt == EXPECTED);
               end else begin
                  r_state <= APPLY;
                  r_idx   <= r_idx + 1'b1;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign bus.stim      = r_idx;
   assign bus.busy      = (r_state != IDLE);
   assign bus.done      = r_done;
   assign bus.pass      = r_pass;
   assign bus.table_out = r_table;
   assign bus.fail_idx  = r_fail_idx;

endmodule

// File: tb/tb_truth_table_checker.sv
// Bench: majority / stuck-at-0 DUT on a default checker, XOR on a 2-input one.
module tb_truth_table_checker;

   typedef struct {
      logic [7:0] tbl;
      logic       pass;
      logic [2:0] fidx;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic zero_q = 1'b0;
   int   n_chk = 0;
   int   n_fail = 0;
   exp_t sb_q[$];

   always #5 clk = ~clk;

   truth_table_checker_if #(.N_IN(3)) bus ();
   truth_table_checker_if #(.N_IN(2)) bus2 ();

   assign bus.q = zero_q ? 1'b0 :
      ((bus.stim[2] & bus.stim[1]) | (bus.stim[1] & bus.stim[0]) |
       (bus.stim[2] & bus.stim[0]));
   assign bus2.q = bus2.stim[1] ^ bus2.stim[0];

   truth_table_checker u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   truth_table_checker #(
      .N_IN     (2),
      .DWELL    (1),
      .EXPECTED (4'h6)
   ) u_dut2 (
      .clk (clk),
      .rst (rst),
      .bus (bus2.slave)
   );

   logic       w_done, w_pass, w_busy;
   logic [7:0] w_tbl;
   logic [2:0] w_fidx;
   bit         sel = 1'b0;

   always_comb begin
      w_done = sel ? bus2.done : bus.done;
      w_pass = sel ? bus2.pass : bus.pass;
      w_busy = sel ? bus2.busy : bus.busy;
      w_tbl  = sel ? {4'h0, bus2.table_out} : bus.table_out;
      w_fidx = sel ? {1'b0, bus2.fail_idx} : bus.fail_idx;
   end

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // mode 0: majority, 1: q stuck at 0, 2: 2-input XOR
   function automatic exp_t model(input int mode);
      exp_t e;
      int   nv;
      logic [7:0] ev;
      logic [2:0] v;
      bit   b, seen;
      nv = (mode == 2) ? 4 : 8;
      ev = (mode == 2) ? 8'h06 : 8'hE8;
      e.tbl = '0; e.fidx = '0; seen = 0;
      for (int k = 0; k < nv; k++) begin
         v = 3'(k);
         case (mode)
            0: b = (v[2] & v[1]) | (v[1] & v[0]) | (v[2] & v[0]);
            1: b = 1'b0;
            default: b = v[1] ^ v[0];
         endcase
         e.tbl[k] = b;
         if (b != ev[k] && !seen) begin
            e.fidx = v;
            seen = 1;
         end
      end
      e.pass = (e.tbl == ev);
      return e;
   endfunction

   task automatic pulse_start(input bit s2, input int mode);
      @(posedge clk); #1;
      if (s2) bus2.start = 1'b1;
      else bus.start = 1'b1;
      sb_q.push_back(model(mode));
      @(posedge clk); #1;
      bus.start = 1'b0;
      bus2.start = 1'b0;
   endtask

   task automatic wait_done(input int exp_cyc, input bit mon,
                            input bit repulse);
      int   cyc;
      exp_t e;
      cyc = 0;
      check("busy_at_start", w_busy, 1);
      check("done_cleared", w_done, 0);
      while (!w_done && cyc < 200) begin
         if (mon) check("stim_step", bus.stim, cyc / 5);
         if (repulse) bus.start = (cyc == 10 || cyc == 25);
         @(posedge clk); #1;
         cyc++;
      end
      bus.start = 1'b0;
      check("done_latency", cyc, exp_cyc);
      check("busy_after", w_busy, 0);
      if (sb_q.size() == 0) begin
         check("sb_empty", 1, 0);
      end else begin
         e = sb_q.pop_front();
         check("table_out", w_tbl, e.tbl);
         check("pass", w_pass, e.pass);
         check("fail_idx", w_fidx, e.fidx);
      end
   endtask

   initial begin
      bus.start = 1'b1;
      bus2.start = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_stim", bus.stim, 0);
      check("rst_busy", bus.busy, 0);
      check("rst_done", bus.done, 0);
      check("rst_pass", bus.pass, 0);
      check("rst_table", bus.table_out, 0);
      check("rst_fidx", bus.fail_idx, 0);
      rst = 1'b0;
      bus.start = 1'b0;

      pulse_start(0, 0);
      check("stim_e0", bus.stim, 0);
      wait_done(40, 1, 0);
      check("stim_idle", bus.stim, 0);

      zero_q = 1'b1;
      pulse_start(0, 1);
      wait_done(40, 0, 0);
      zero_q = 1'b0;

      pulse_start(0, 0);
      wait_done(40, 0, 1);
      pulse_start(0, 0);
      wait_done(40, 0, 0);

      pulse_start(0, 0);
      repeat (17) @(posedge clk);
      #1;
      check("mid_busy", bus.busy, 1);
      rst = 1'b1;
      #1;
      check("arst_stim", bus.stim, 0);
      check("arst_busy", bus.busy, 0);
      check("arst_done", bus.done, 0);
      check("arst_table", bus.table_out, 0);
      check("arst_fidx", bus.fail_idx, 0);
      void'(sb_q.pop_front());
      @(posedge clk); #1;
      rst = 1'b0;
      pulse_start(0, 0);
      wait_done(40, 0, 0);

      sel = 1'b1;
      pulse_start(1, 2);
      wait_done(8, 0, 0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
